// File: rtl/sprite_collision_rng.sv
// sprite_collision_rng: registered paddle/ball hitbox overlap flags plus a free-running 16-bit LFSR.
// Define SPRITE_EDGE_HITBOX_EN to build the top/bottom edge-strip hitboxes (coll_o[2:1]).
module sprite_collision_rng #(
  parameter int X_POS_W   = 10,
  parameter int Y_POS_W   = 10,
  parameter int RND_NUM_W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [X_POS_W-1:0]   pad_x_i,
  input  logic [X_POS_W-1:0]   pad_right_i,
  input  logic [Y_POS_W-1:0]   pad_y_i,
  input  logic [Y_POS_W-1:0]   pad_bottom_i,
  input  logic [X_POS_W-1:0]   ball_x_i,
  input  logic [X_POS_W-1:0]   ball_right_i,
  input  logic [Y_POS_W-1:0]   ball_y_i,
  input  logic [Y_POS_W-1:0]   ball_bottom_i,
  output logic [2:0]           coll_o,
  output logic [RND_NUM_W-1:0] rnd_num_o
);
  logic [15:0] r_lfsr;
  logic [2:0]  r_coll;
  logic [2:0]  w_hit;
  logic        w_x_ovl;
  assign w_x_ovl  = (pad_x_i < ball_right_i) && (pad_right_i > ball_x_i);
  assign w_hit[0] = w_x_ovl && (pad_y_i < ball_bottom_i) && (pad_bottom_i > ball_y_i);
`ifdef SPRITE_EDGE_HITBOX_EN
  logic [Y_POS_W-1:0] w_top_bottom;
  logic [Y_POS_W-1:0] w_bot_top;
  // One-pixel strips along the paddle's top and bottom rows; wraps modulo 2^Y_POS_W
  assign w_top_bottom = pad_y_i + Y_POS_W'(1);
  assign w_bot_top    = pad_bottom_i - Y_POS_W'(1);
  assign w_hit[1] = w_x_ovl && (pad_y_i < ball_bottom_i) && (w_top_bottom > ball_y_i);
  assign w_hit[2] = w_x_ovl && (w_bot_top < ball_bottom_i) && (pad_bottom_i > ball_y_i);
`else
  assign w_hit[2:1] = 2'b00;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_coll <= 3'b000;
      r_lfsr <= 16'hACE1;
    end else begin
      r_coll <= w_hit;
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end
  assign coll_o    = r_coll;
  assign rnd_num_o = r_lfsr[RND_NUM_W-1:0];
endmodule

// File: tb/tb_sprite_collision_rng.sv
// tb_sprite_collision_rng: directed collision cases through a scoreboard queue, LFSR checked against a bench model.
module tb_sprite_collision_rng;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pad_x, pad_right, ball_x, ball_right;
  logic [9:0]  pad_y, pad_bottom, ball_y, ball_bottom;
  logic [2:0]  coll;
  logic [15:0] rnd;
  logic [15:0] m;
  typedef struct {string tag; logic [2:0] coll;} exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
`ifdef SPRITE_EDGE_HITBOX_EN
  localparam logic [2:0] E_TOP = 3'b011, E_BOT = 3'b101, E_ALL = 3'b111;
`else
  localparam logic [2:0] E_TOP = 3'b001, E_BOT = 3'b001, E_ALL = 3'b001;
`endif

  sprite_collision_rng #(.X_POS_W(10), .Y_POS_W(10), .RND_NUM_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .pad_x_i(pad_x), .pad_right_i(pad_right), .pad_y_i(pad_y), .pad_bottom_i(pad_bottom),
    .ball_x_i(ball_x), .ball_right_i(ball_right), .ball_y_i(ball_y), .ball_bottom_i(ball_bottom),
    .coll_o(coll), .rnd_num_o(rnd)
  );

  always #5 clk = ~clk;

  task automatic ball(input int x, input int r, input int y, input int b);
    ball_x = 10'(x); ball_right = 10'(r); ball_y = 10'(y); ball_bottom = 10'(b);
  endtask

  task automatic pad(input int x, input int r, input int y, input int b);
    pad_x = 10'(x); pad_right = 10'(r); pad_y = 10'(y); pad_bottom = 10'(b);
  endtask

  task automatic step(input string tag, input logic [2:0] ec, input logic r);
    exp_t e;
    q.push_back('{tag, ec});
    rst = r;
    @(posedge clk);
    #1;
    m = r ? 16'hACE1 : {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    e = q.pop_front();
    n_vec++;
    assert (coll === e.coll) else begin
      n_err++;
      $error("FAIL %s coll_o=%b expected %b", e.tag, coll, e.coll);
    end
    n_vec++;
    assert (rnd === m) else begin
      n_err++;
      $error("FAIL %s_rnd rnd=%h expected %h", e.tag, rnd, m);
    end
  endtask

  task automatic chk_rnd(input string tag, input logic [15:0] exp);
    n_vec++;
    assert (rnd === exp) else begin
      n_err++;
      $error("FAIL %s rnd=%h expected %h", tag, rnd, exp);
    end
  endtask

  initial begin
    m = 16'h0;
    rst = 1'b1;
    pad(20, 30, 100, 164);
    ball(25, 33, 130, 138);
    step("reset", 3'b000, 1'b1);
    chk_rnd("reset_val", 16'hACE1);
    n_vec++;
    assert (rnd[8:0] === 9'h0E1) else begin
      n_err++;
      $error("FAIL reset_low9 rnd=%h expected %h", rnd[8:0], 9'h0E1);
    end
    step("center", 3'b001, 1'b0);
    chk_rnd("first_step", 16'h59C3);
    ball(25, 33, 95, 103);   step("top_strip", E_TOP, 1'b0);
    ball(25, 33, 160, 168);  step("bot_strip", E_BOT, 1'b0);
    ball(30, 38, 130, 138);  step("right_edge", 3'b000, 1'b0);
    ball(12, 20, 130, 138);  step("left_edge", 3'b000, 1'b0);
    ball(25, 33, 164, 170);  step("bottom_edge", 3'b000, 1'b0);
    ball(25, 33, 92, 100);   step("top_edge", 3'b000, 1'b0);
    ball(500, 510, 500, 510); step("far", 3'b000, 1'b0);
    pad(20, 30, 100, 102);
    ball(25, 33, 99, 103);   step("all_three", E_ALL, 1'b0);
    pad(20, 30, 1000, 0);
    ball(25, 33, 1010, 1023); step("wrap", 3'b000, 1'b0);
    pad(20, 30, 100, 164);
    ball(25, 33, 130, 138);  step("pre_rst", 3'b001, 1'b0);
    step("mid_rst", 3'b000, 1'b1);
    step("post_rst", 3'b001, 1'b0);
    step("mid_rst2", 3'b000, 1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge clk);
      #1;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      n_vec++;
      assert (rnd === m && rnd !== 16'h0000) else begin
        n_err++;
        $error("FAIL period_step%0d rnd=%h expected %h", i, rnd, m);
      end
    end
    chk_rnd("period_wrap", 16'hACE1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
